// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered value that commits only at frame wrap.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS           = 4,
    parameter int CYCLES_PER_DIGIT = 100000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic                  BLANK,
    output logic                  PENDING,
    output logic                  FRAME,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int DIV_W = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    div_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [4*DIGITS-1:0] staging_reg;
    logic [DIGITS-1:0]   staging_dp_reg;
    logic [4*DIGITS-1:0] shadow_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;

    logic                last_div;
    logic                commit;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;

    assign last_div = (div_reg == DIV_W'(CYCLES_PER_DIGIT - 1));
    assign commit   = last_div && (idx_reg == IDX_W'(DIGITS - 1));

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

`ifdef SEG7_LZB_EN
    // lz_blank[i] is set when nibbles i..DIGITS-1 of the shown value are all zero
    logic [DIGITS-1:0] lz_blank;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_blank[gi] = 1'b0;
            end else begin : g_rest
                assign lz_blank[gi] = (shadow_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_nib = shadow_reg[4*i +: 4];
                cur_dp  = shadow_dp_reg[i];
`ifdef SEG7_LZB_EN
                cur_blank = lz_blank[i];
`endif
                // div==0 is the ghost-guard cycle: no anode while segments settle
                if (div_reg != '0 && !BLANK)
                    an_next[i] = 1'b0;
            end
        end
        seg_next = cur_blank ? 7'b1111111 : hex_to_seg(cur_nib);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_reg        <= '0;
            idx_reg        <= '0;
            staging_reg    <= '0;
            staging_dp_reg <= '0;
            shadow_reg     <= '0;
            shadow_dp_reg  <= '0;
            PENDING        <= 1'b0;
            FRAME          <= 1'b0;
            AN             <= '1;
            seg            <= 7'b1111111;
            dp             <= 1'b1;
        end else begin
            if (last_div) begin
                div_reg <= '0;
                idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end

            FRAME <= commit;

            if (commit) begin
                // A LOAD coinciding with the commit is newer than anything staged
                if (LOAD) begin
                    shadow_reg    <= VALUE;
                    shadow_dp_reg <= DP_IN;
                end else if (PENDING) begin
                    shadow_reg    <= staging_reg;
                    shadow_dp_reg <= staging_dp_reg;
                end
                PENDING <= 1'b0;
            end else if (LOAD) begin
                staging_reg    <= VALUE;
                staging_dp_reg <= DP_IN;
                PENDING        <= 1'b1;
            end

            AN  <= an_next;
            seg <= seg_next;
            dp  <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, CYCLES_PER_DIGIT=4); expected frames are queued and popped per frame.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int C = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] VALUE = '0;
    logic        LOAD = 1'b0;
    logic [3:0]  DP_IN = '0;
    logic        BLANK = 1'b0;
    logic        PENDING;
    logic        FRAME;
    logic [3:0]  AN;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
    } frame_t;
    frame_t sb[$];

    seg7_scan_driver #(.DIGITS(D), .CYCLES_PER_DIGIT(C)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .LOAD(LOAD), .DP_IN(DP_IN),
        .BLANK(BLANK), .PENDING(PENDING), .FRAME(FRAME), .AN(AN), .seg(seg), .dp(dp)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
`ifdef SEG7_LZB_EN
        if (d > 0 && (v >> (4*d)) == 16'd0) return 7'b1111111;
`endif
        return dec(v[4*d +: 4]);
    endfunction

    task automatic wait_frame(input logic exp_pend);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            n_tests++;
            if (FRAME === 1'b1) begin
                seen = 1;
                if (PENDING !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pending_at_frame: got %b want 0", PENDING);
                end
            end else if (PENDING !== exp_pend) begin
                n_fail++;
                $display("FAIL pending_wait: got %b want %b", PENDING, exp_pend);
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: no FRAME within 40 cycles");
        end
    endtask

    // Called at the negedge where FRAME is high; checks the 16 cycles of the next frame.
    task automatic check_frame(input int la, input logic [15:0] va, input logic [3:0] da,
                               input int lb, input logic [15:0] vb, input logic [3:0] db);
        frame_t f;
        logic exp_pend = 1'b0;
        logic [3:0] exp_an;
        int errs = 0;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected frame queued");
            return;
        end
        f = sb.pop_front();
        for (int c = 0; c < 16; c++) begin
            int d = c / C;
            int ph = c % C;
            @(negedge CLK);
            exp_an = (ph == 0) ? 4'hF : ~(4'b0001 << d);
            if (c == 15) exp_pend = 1'b0;
            n_tests += 5;
            if (AN !== exp_an) begin
                n_fail++; errs++;
                $display("FAIL an c=%0d: got %b want %b", c, AN, exp_an);
            end
            if (seg !== exp_seg(f.v, d)) begin
                n_fail++; errs++;
                $display("FAIL seg c=%0d: got %b want %b", c, seg, exp_seg(f.v, d));
            end
            if (dp !== ~f.d[d]) begin
                n_fail++; errs++;
                $display("FAIL dp c=%0d: got %b want %b", c, dp, ~f.d[d]);
            end
            if (FRAME !== (c == 15)) begin
                n_fail++; errs++;
                $display("FAIL frame c=%0d: got %b want %b", c, FRAME, (c == 15));
            end
            if (PENDING !== exp_pend) begin
                n_fail++; errs++;
                $display("FAIL pending c=%0d: got %b want %b", c, PENDING, exp_pend);
            end
            if (c == la) begin
                LOAD = 1'b1; VALUE = va; DP_IN = da;
                if (c < 14) exp_pend = 1'b1;
            end else if (c == lb) begin
                LOAD = 1'b1; VALUE = vb; DP_IN = db;
                if (c < 14) exp_pend = 1'b1;
            end else begin
                LOAD = 1'b0;
            end
        end
        $display("[TB] frame value=%h dp=%b checked, errors=%0d", f.v, f.d, errs);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            LOAD = ~LOAD;
            VALUE = 16'($urandom);
            n_tests++;
            if (AN !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || PENDING !== 1'b0 || FRAME !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: AN=%b seg=%b dp=%b PENDING=%b FRAME=%b want 1111 1111111 1 0 0",
                         AN, seg, dp, PENDING, FRAME);
            end
        end
        LOAD = 1'b0; VALUE = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (AN !== 4'hF || seg !== 7'b1000000 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_guard: AN=%b seg=%b dp=%b want 1111 1000000 1", AN, seg, dp);
        end
        @(negedge CLK);
        n_tests++;
        if (AN !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_first_slot: AN=%b seg=%b want 1110 1000000", AN, seg);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_load_scan();
        LOAD = 1'b1; VALUE = 16'h1234; DP_IN = 4'b0100;
        @(negedge CLK);
        LOAD = 1'b0;
        n_tests++;
        if (PENDING !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_rise: got %b want 1", PENDING);
        end
        sb.push_back('{v: 16'h1234, d: 4'b0100});
        wait_frame(1'b1);
        check_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_no_tearing();
        sb.push_back('{v: 16'h1234, d: 4'b0100});
        sb.push_back('{v: 16'h00FF, d: 4'b0001});
        check_frame(5, 16'hABCD, 4'b0000, 10, 16'h00FF, 4'b0001);
        check_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_back_to_back_commit();
        sb.push_back('{v: 16'h00FF, d: 4'b0001});
        sb.push_back('{v: 16'h5555, d: 4'b0000});
        check_frame(14, 16'h5555, 4'b0000, -1, '0, '0);
        check_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_lzb();
        sb.push_back('{v: 16'h5555, d: 4'b0000});
        sb.push_back('{v: 16'h0005, d: 4'b0000});
        check_frame(3, 16'h0005, 4'b0000, -1, '0, '0);
        check_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_blank_reset();
        BLANK = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            n_tests += 2;
            if (AN !== 4'hF) begin
                n_fail++;
                $display("FAIL blank_an k=%0d: got %b want 1111", k, AN);
            end
            if (FRAME !== (k % 16 == 0)) begin
                n_fail++;
                $display("FAIL blank_frame k=%0d: got %b want %b", k, FRAME, (k % 16 == 0));
            end
        end
        BLANK = 1'b0;
        $display("[TB] blank checked over two frames");
        repeat (5) @(negedge CLK);
        LOAD = 1'b1; VALUE = 16'h9999; DP_IN = 4'hF;
        @(negedge CLK);
        LOAD = 1'b0;
        n_tests++;
        if (PENDING !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_before_reset: got %b want 1", PENDING);
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if (AN !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || PENDING !== 1'b0 || FRAME !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: AN=%b seg=%b dp=%b PENDING=%b FRAME=%b want 1111 1111111 1 0 0",
                     AN, seg, dp, PENDING, FRAME);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (AN !== 4'hF || seg !== 7'b1000000 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_guard: AN=%b seg=%b dp=%b want 1111 1000000 1", AN, seg, dp);
        end
        @(negedge CLK);
        n_tests++;
        if (AN !== 4'b1110) begin
            n_fail++;
            $display("FAIL post_reset_slot: AN=%b want 1110", AN);
        end
        sb.push_back('{v: 16'h0000, d: 4'b0000});
        wait_frame(1'b0);
        check_frame(-1, '0, '0, -1, '0, '0);
        $display("[TB] mid-frame reset checked");
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_no_tearing();
        test_back_to_back_commit();
        test_lzb();
        test_blank_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
